// File: rtl/arbitro_escritura_banco_pkg.sv
// Shared widths, FSM encoding and saturating-increment helper for the bank write arbiter.
package arbitro_escritura_banco_pkg;

  localparam int ANCHO_DIR  = 5;
  localparam int ANCHO_DATO = 32;
  localparam int ANCHO_CONT = 16;

  // WRITE is encoded as 1 so WE_BANCO is taken straight from the state flop.
  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } estado_t;

  function automatic logic [ANCHO_CONT-1:0] sat_inc(input logic [ANCHO_CONT-1:0] v);
    return (&v) ? v : v + {{(ANCHO_CONT-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way round-robin grant: combinational grants, pointer moves to the other side after any grant.
module arbitro_rr2 #(
  parameter bit PRIO_INICIAL = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic VALID0,
  input  logic VALID1,
  input  logic ENABLE,
  output logic GRANT0,
  output logic GRANT1
);

  logic ptr;

  always_comb begin
    GRANT0 = ENABLE & VALID0 & (~VALID1 | ~ptr);
    GRANT1 = ENABLE & VALID1 & (~VALID0 |  ptr);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr <= PRIO_INICIAL;
    end else if (GRANT0) begin
      ptr <= 1'b1;
    end else if (GRANT1) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/arbitro_escritura_banco.sv
// Arbitrates two write requesters into one registered bank write port (latency 1, one write/cycle).
// HOLD_BANCO freezes the output stage and blocks both READYs.
module arbitro_escritura_banco
  import arbitro_escritura_banco_pkg::*;
#(
  parameter bit PRIO_INICIAL = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ0_VALID,
  input  logic [ANCHO_DIR-1:0]  REQ0_WA,
  input  logic [ANCHO_DATO-1:0] REQ0_DW,
  output logic                  REQ0_READY,
  input  logic                  REQ1_VALID,
  input  logic [ANCHO_DIR-1:0]  REQ1_WA,
  input  logic [ANCHO_DATO-1:0] REQ1_DW,
  output logic                  REQ1_READY,
  input  logic                  HOLD_BANCO,
  output logic [ANCHO_DIR-1:0]  WA_BANCO,
  output logic [ANCHO_DATO-1:0] DW_BANCO,
  output logic                  WE_BANCO,
  output logic                  BUSY,
  output logic [ANCHO_CONT-1:0] WR_COUNT
);

  estado_t estado, estado_sig;
  logic    habilita;
  logic    transfer;

  // Reset gates the grants so no requester sees READY while the block is held in reset.
  assign habilita = ~HOLD_BANCO & RST_N;
  assign transfer = REQ0_READY | REQ1_READY;

  arbitro_rr2 #(
    .PRIO_INICIAL(PRIO_INICIAL)
  ) u_rr (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .VALID0 (REQ0_VALID),
    .VALID1 (REQ1_VALID),
    .ENABLE (habilita),
    .GRANT0 (REQ0_READY),
    .GRANT1 (REQ1_READY)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      estado <= IDLE;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    if (!HOLD_BANCO) begin
      estado_sig = transfer ? WRITE : IDLE;
    end
  end

  assign WE_BANCO = (estado == WRITE);
  assign BUSY     = WE_BANCO;

  // Address/data only change on a transfer, so they keep their last value in IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WA_BANCO <= '0;
      DW_BANCO <= '0;
    end else if (transfer) begin
      WA_BANCO <= REQ0_READY ? REQ0_WA : REQ1_WA;
      DW_BANCO <= REQ0_READY ? REQ0_DW : REQ1_DW;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WR_COUNT <= '0;
    end else if (WE_BANCO && !HOLD_BANCO) begin
      WR_COUNT <= sat_inc(WR_COUNT);
    end
  end

endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// Directed bench for arbitro_escritura_banco with a write scoreboard checked at every bank commit.
module tb_arbitro_escritura_banco;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ0_VALID, REQ1_VALID, HOLD_BANCO;
  logic [4:0]  REQ0_WA, REQ1_WA;
  logic [31:0] REQ0_DW, REQ1_DW;
  logic        REQ0_READY, REQ1_READY;
  logic [4:0]  WA_BANCO;
  logic [31:0] DW_BANCO;
  logic        WE_BANCO, BUSY;
  logic [15:0] WR_COUNT;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [36:0] sb[$];
  logic        ptr_m;
  logic [15:0] exp_count;
  logic [15:0] cnt_snap;

  arbitro_escritura_banco #(.PRIO_INICIAL(1'b0)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ0_VALID (REQ0_VALID),
    .REQ0_WA    (REQ0_WA),
    .REQ0_DW    (REQ0_DW),
    .REQ0_READY (REQ0_READY),
    .REQ1_VALID (REQ1_VALID),
    .REQ1_WA    (REQ1_WA),
    .REQ1_DW    (REQ1_DW),
    .REQ1_READY (REQ1_READY),
    .HOLD_BANCO (HOLD_BANCO),
    .WA_BANCO   (WA_BANCO),
    .DW_BANCO   (DW_BANCO),
    .WE_BANCO   (WE_BANCO),
    .BUSY       (BUSY),
    .WR_COUNT   (WR_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at posedge+1, check READY against the arbitration model,
  // record the expected bank write, then advance to the next posedge+1.
  task automatic cycle(input logic v0, input logic [4:0] wa0, input logic [31:0] dw0,
                       input logic v1, input logic [4:0] wa1, input logic [31:0] dw1,
                       input logic h);
    logic g0, g1;
    REQ0_VALID = v0; REQ0_WA = wa0; REQ0_DW = dw0;
    REQ1_VALID = v1; REQ1_WA = wa1; REQ1_DW = dw1;
    HOLD_BANCO = h;
    #1;
    g0 = !h && v0 && (!v1 || ptr_m == 1'b0);
    g1 = !h && v1 && (!v0 || ptr_m == 1'b1);
    check("ready0", REQ0_READY, g0);
    check("ready1", REQ1_READY, g1);
    if (g0) begin sb.push_back({wa0, dw0}); ptr_m = 1'b1; end
    if (g1) begin sb.push_back({wa1, dw1}); ptr_m = 1'b0; end
    @(posedge CLK); #1;
  endtask

  // A bank commit is a clock edge with WE_BANCO=1 and HOLD_BANCO=0.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && WE_BANCO === 1'b1 && HOLD_BANCO === 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_commit", 1'b1, 1'b0);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        check("commit_wa", WA_BANCO, e[36:32]);
        check("commit_dw", DW_BANCO, e[31:0]);
      end
      if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    end
  end

  initial begin
    RST_N = 1'b0; HOLD_BANCO = 1'b0;
    REQ0_VALID = 1'b1; REQ0_WA = 5'd3; REQ0_DW = 32'h1;
    REQ1_VALID = 1'b1; REQ1_WA = 5'd4; REQ1_DW = 32'h2;
    ptr_m = 1'b0; exp_count = 16'd0;
    #2;
    check("rst_we", WE_BANCO, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_wa", WA_BANCO, 5'd0);
    check("rst_dw", DW_BANCO, 32'd0);
    check("rst_count", WR_COUNT, 16'd0);
    check("rst_ready0", REQ0_READY, 1'b0);
    check("rst_ready1", REQ1_READY, 1'b0);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Single write, latency 1
    cycle(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 1'b0);
    check("single_we", WE_BANCO, 1'b1);
    check("single_wa", WA_BANCO, 5'd5);
    check("single_dw", DW_BANCO, 32'hA5A5A5A5);
    check("single_busy", BUSY, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    check("single_we_drop", WE_BANCO, 1'b0);
    check("single_count", WR_COUNT, 16'd1);
    check("idle_wa_kept", WA_BANCO, 5'd5);
    check("idle_dw_kept", DW_BANCO, 32'hA5A5A5A5);

    // Lone REQ1 write hands priority back to requester 0
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 1'b0);

    // Round-robin alternation with sustained throughput
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 5'd1, 32'h1000_0000 + i, 1'b1, 5'd2, 32'h2000_0000 + i, 1'b0);
      check("rr_we", WE_BANCO, 1'b1);
      check("rr_wa", WA_BANCO, (i % 2 == 0) ? 5'd1 : 5'd2);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    check("rr_count", WR_COUNT, 16'd6);

    // Same address from both: REQ0 first, REQ1 overwrites one cycle later
    cycle(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 1'b0);
    check("same_wa_first", WA_BANCO, 5'd7);
    check("same_dw_first", DW_BANCO, 32'd1);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd2, 1'b0);
    check("same_dw_second", DW_BANCO, 32'd2);
    check("same_we_second", WE_BANCO, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    check("same_final_dw", DW_BANCO, 32'd2);
    check("same_count", WR_COUNT, 16'd8);

    // HOLD_BANCO during WRITE
    cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0);
    cnt_snap = WR_COUNT;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b1);
      check("hold_we", WE_BANCO, 1'b1);
      check("hold_wa", WA_BANCO, 5'd9);
      check("hold_dw", DW_BANCO, 32'h99);
      check("hold_count", WR_COUNT, cnt_snap);
    end
    cycle(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b0);
    check("resume_wa", WA_BANCO, 5'd11);
    check("resume_count", WR_COUNT, cnt_snap + 16'd1);
    cycle(1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 32'd0, 1'b0);
    check("resume_wa2", WA_BANCO, 5'd10);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    check("model_count", WR_COUNT, exp_count);

    // Asynchronous reset while a write is in flight
    cycle(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0);
    check("pre_rst_we", WE_BANCO, 1'b1);
    RST_N = 1'b0;
    #1;
    check("arst_we", WE_BANCO, 1'b0);
    check("arst_busy", BUSY, 1'b0);
    check("arst_count", WR_COUNT, 16'd0);
    check("arst_ready0", REQ0_READY, 1'b0);
    sb.delete();
    exp_count = 16'd0;
    ptr_m = 1'b0;
    REQ0_VALID = 1'b0;
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    #1;
    check("post_rst_ptr0", REQ0_READY, 1'b1);
    check("post_rst_ptr1", REQ1_READY, 1'b0);
    @(posedge CLK); #1;
    sb.push_back({REQ0_WA, REQ0_DW});
    ptr_m = 1'b1;
    REQ1_VALID = 1'b0;

    // Counter saturation
    for (int i = 0; i < 65540; i++) begin
      cycle(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'd0, 1'b0);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    check("sat_count", WR_COUNT, 16'hFFFF);
    check("sat_model", WR_COUNT, exp_count);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_escritura_banco.md
ARBITRO_ESCRITURA_BANCO -- requirements
Module: arbitro_escritura_banco

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named CLK and RST_N.
REQ-002 Parameter PRIO_INICIAL, default 0, SHALL set which requester holds priority after reset.
REQ-003 Ports SHALL be:
 CLK  in  1  rising-edge clock
 RST_N  in  1  asynchronous active-low reset
 REQ0_VALID  in  1  requester 0 has a write pending
 REQ0_WA  in  5  requester 0 target register
 REQ0_DW  in  32  requester 0 write data
 REQ0_READY  out  1  requester 0 write accepted this cycle
 REQ1_VALID, REQ1_WA, REQ1_DW, REQ1_READY  same as requester 0
 HOLD_BANCO  in  1  bank busy: no accept, no drain
 WA_BANCO  out  5  bank write address, registered
 DW_BANCO  out  32  bank write data, registered
 WE_BANCO  out  1  bank write enable, registered, glitch-free
 BUSY  out  1  output stage holds a write
 WR_COUNT  out  16  committed-write counter, saturating

Function
REQ-004 A transfer SHALL occur on a rising CLK edge where REQi_VALID and REQi_READY are both 1.
REQ-005 Requesters SHALL hold VALID, WA and DW stable until accepted; the block SHALL NOT require READY before VALID.
REQ-006 REQi_READY SHALL be combinational from VALIDs, HOLD_BANCO, and the priority pointer; at most one READY high per cycle.
REQ-007 Both READY SHALL be 0 while HOLD_BANCO=1.
REQ-008 With one VALID and HOLD_BANCO=0, that requester SHALL get READY in the same cycle.
REQ-009 With both VALID, the requester named by the pointer SHALL win; the pointer SHALL then point to the loser (round-robin).
REQ-010 A winner alone SHALL leave the pointer at the other requester.
REQ-011 The FSM SHALL have states IDLE (output stage empty) and WRITE (output stage full, WE_BANCO=1).
REQ-012 IDLE->WRITE on a transfer; WRITE->WRITE on a transfer while draining; WRITE->IDLE when draining with no transfer; any state holds while HOLD_BANCO=1.
REQ-013 A transfer SHALL load WA_BANCO/DW_BANCO from the winner; WE_BANCO SHALL assert exactly one cycle after acceptance (latency 1).
REQ-014 WE_BANCO SHALL remain high for exactly one cycle per accepted write, except that it stays high with unchanged WA/DW while HOLD_BANCO=1.
REQ-015 Back-to-back transfers SHALL give sustained throughput of one write per cycle.
REQ-016 Same WA from both requesters in one cycle SHALL be serialized by REQ-009; the loser's write SHALL commit one cycle later, overwriting the winner.
REQ-017 In IDLE, WA_BANCO and DW_BANCO SHALL retain their last values; only WE_BANCO drops.
REQ-018 BUSY SHALL equal WE_BANCO.
REQ-019 WR_COUNT SHALL increment on each cycle with WE_BANCO=1 and HOLD_BANCO=0, and saturate at 16'hFFFF.

Reset
REQ-020 On RST_N=0, regardless of CLK, state SHALL be IDLE; WE_BANCO, BUSY, WA_BANCO, DW_BANCO and WR_COUNT SHALL be 0; the pointer SHALL equal PRIO_INICIAL.
REQ-021 Both READY SHALL be 0 while RST_N=0; a write in flight SHALL be dropped without commit.
REQ-022 Reset release SHALL take effect on the first rising CLK edge after RST_N rises.

Structure
REQ-023 A shared package SHALL hold the address width (5), data width (32), counter width (16) and the IDLE/WRITE state encoding.
REQ-024 Round-robin grant logic SHALL be a sub-module, arbitro_rr2, with pointer state, inputs VALID0/1 and enable, and outputs GRANT0/1.

Verification
REQ-025 Reset, then REQ0 VALID with WA=5, DW=32'hA5A5A5A5 -> REQ0_READY=1 in the same cycle; next cycle WE_BANCO=1, WA_BANCO=5, DW_BANCO=32'hA5A5A5A5; then WE_BANCO=0, WR_COUNT=1.
REQ-026 PRIO_INICIAL=0, both VALID for 4 cycles (REQ0 WA=1, REQ1 WA=2) -> grants alternate 0,1,0,1; WA_BANCO sequence 1,2,1,2 with WE_BANCO high for 4 consecutive cycles.
REQ-027 Both VALID with WA=7, DW0=1, DW1=2 -> two consecutive writes to 7, REQ0's data first; final committed value 2.
REQ-028 HOLD_BANCO=1 for 3 cycles during WRITE -> both READY=0, WE_BANCO held high, WA/DW unchanged, WR_COUNT unchanged; resumes on release.
REQ-029 RST_N low while WE_BANCO=1 -> WE_BANCO=0 immediately without a clock edge; WR_COUNT=0; pointer=PRIO_INICIAL.
REQ-030 Preload WR_COUNT near 16'hFFFF by driving 65,536+ writes -> WR_COUNT stays at 16'hFFFF.
